// File: rtl/colorbar_pkg.sv
// Shared constants for the colour-bar pattern sequencer: host mode codes,
// controller state codes and default field widths.
package colorbar_pkg;

   localparam logic [1:0] MODE_HOLD = 2'd0;
   localparam logic [1:0] MODE_AUTO = 2'd1;
   localparam logic [1:0] MODE_STEP = 2'd2;
   localparam logic [1:0] MODE_STOP = 2'd3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SYNC = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam int DEF_PAT_W   = 3;
   localparam int DEF_DWELL_W = 8;
   localparam int DEF_FCNT_W  = 16;

endpackage

// File: rtl/colorbar_fv_edge.sv
// Frame-boundary detector: registers fv_in and pulses bnd for the single
// cycle in which fv_in is first sampled low after being high.
module colorbar_fv_edge (
   input  logic clk,
   input  logic rstn,
   input  logic fv_in,
   output logic bnd
);

   logic fv_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fv_d <= 1'b0;
      end else begin
         fv_d <= fv_in;
      end
   end

   assign bnd = fv_d & ~fv_in;

endmodule

// File: rtl/colorbar_pattern_seq.sv
// Frame-synchronous controller for the colour-bar generator: shadows host
// config, applies it on frame boundaries, auto/step cycles the pattern index.
// Optional watchdog enabled by defining COLORBAR_SEQ_WDOG_EN.
module colorbar_pattern_seq
   import colorbar_pkg::*;
#(
   parameter int NUM_PATTERNS = 8,
   parameter int PAT_W        = DEF_PAT_W,
   parameter int DWELL_W      = DEF_DWELL_W,
   parameter int FCNT_W       = DEF_FCNT_W,
   parameter int WDOG_CYCLES  = 4950000
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               fv_in,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [1:0]         cfg_mode,
   input  logic [PAT_W-1:0]   cfg_pat,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               step,
   output logic               gen_en,
   output logic [PAT_W-1:0]   pat_sel,
   output logic [FCNT_W-1:0]  frame_cnt,
   output logic               busy,
   output logic               wdog_err,
   output logic [1:0]         state
);

   // cfg_valid/cfg_ready: a config transfers on a rising edge where both are
   // high; cfg_valid may stay high while cfg_ready is low and is taken later.
   logic               bnd;
   logic               pending;
   logic               step_pend;
   logic [1:0]         sh_mode;
   logic [PAT_W-1:0]   sh_pat;
   logic [DWELL_W-1:0] sh_dwell;
   logic [1:0]         mode;
   logic [DWELL_W-1:0] dwell;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [DWELL_W-1:0] dwell_last;
   logic [PAT_W-1:0]   pat_inc;
   logic               accept;
   logic               apply;
   logic               run_bnd;
   logic               step_set;
   logic               step_take;
   logic               wdog_fire;

   colorbar_fv_edge u_fv_edge (
      .clk   (clk),
      .rstn  (rstn),
      .fv_in (fv_in),
      .bnd   (bnd)
   );

   assign cfg_ready  = ~pending;
   assign busy       = (state != ST_IDLE);
   assign gen_en     = busy;
   assign accept     = cfg_valid & cfg_ready;
   // pending is registered, so a config accepted on a boundary waits one frame
   assign apply      = bnd & pending & busy;
   assign run_bnd    = bnd & (state == ST_RUN) & ~pending;
   assign step_set   = step & (state == ST_RUN) & (mode == MODE_STEP);
   assign step_take  = run_bnd & (mode == MODE_STEP) & step_pend;
   assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
   assign pat_inc    = (pat_sel == PAT_W'(NUM_PATTERNS - 1)) ? '0 : pat_sel + PAT_W'(1);

`ifdef COLORBAR_SEQ_WDOG_EN
   logic [31:0] wdog_cnt;
   logic        wdog_err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wdog_cnt   <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         if (bnd || !busy) begin
            wdog_cnt <= '0;
         end else begin
            wdog_cnt <= wdog_cnt + 32'd1;
         end
         if (wdog_fire) begin
            wdog_err_q <= 1'b1;
         end
      end
   end

   assign wdog_fire = busy & ~bnd & (wdog_cnt == 32'(WDOG_CYCLES - 1));
   assign wdog_err  = wdog_err_q;
`else
   assign wdog_fire = 1'b0;
   assign wdog_err  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         pending   <= 1'b0;
         step_pend <= 1'b0;
         sh_mode   <= MODE_HOLD;
         sh_pat    <= '0;
         sh_dwell  <= '0;
         mode      <= MODE_HOLD;
         dwell     <= '0;
         dwell_cnt <= '0;
         pat_sel   <= '0;
         frame_cnt <= '0;
      end else begin
         if (accept) begin
            sh_mode  <= cfg_mode;
            sh_pat   <= cfg_pat;
            sh_dwell <= cfg_dwell;
         end

         if (wdog_fire) begin
            pending <= 1'b0;
         end else if (accept) begin
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end

         if (step_set) begin
            step_pend <= 1'b1;
         end else if (apply || step_take || wdog_fire) begin
            step_pend <= 1'b0;
         end

         if (wdog_fire) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: if (accept) state <= ST_SYNC;
               ST_SYNC: if (apply) state <= (sh_mode == MODE_STOP) ? ST_IDLE : ST_RUN;
               ST_RUN:  if (apply && sh_mode == MODE_STOP) state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end

         if (bnd && state == ST_RUN) begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
         end

         // STOP keeps the last pattern on screen history; other modes load it
         if (apply) begin
            mode      <= sh_mode;
            dwell     <= sh_dwell;
            dwell_cnt <= '0;
            if (sh_mode != MODE_STOP) begin
               pat_sel <= sh_pat;
            end
         end else if (run_bnd && mode == MODE_AUTO) begin
            if (dwell_cnt == dwell_last) begin
               pat_sel   <= pat_inc;
               dwell_cnt <= '0;
            end else begin
               dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
         end else if (step_take) begin
            pat_sel <= pat_inc;
         end
      end
   end

endmodule

// File: tb/tb_colorbar_pattern_seq.sv
// Directed bench for colorbar_pattern_seq: driver pushes hand-computed
// output snapshots into a queue, a negedge monitor pops and compares them.
module tb_colorbar_pattern_seq;

   localparam int W = 23;

   logic        clk;
   logic        rstn;
   logic        fv_in;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_mode;
   logic [2:0]  cfg_pat;
   logic [7:0]  cfg_dwell;
   logic        step;
   logic        gen_en;
   logic [2:0]  pat_sel;
   logic [15:0] frame_cnt;
   logic        busy;
   logic        wdog_err;
   logic [1:0]  state;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           compared;
   int           mismatched;

   colorbar_pattern_seq #(
      .NUM_PATTERNS (8),
      .PAT_W        (3),
      .DWELL_W      (8),
      .FCNT_W       (16),
      .WDOG_CYCLES  (100)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .fv_in     (fv_in),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_mode  (cfg_mode),
      .cfg_pat   (cfg_pat),
      .cfg_dwell (cfg_dwell),
      .step      (step),
      .gen_en    (gen_en),
      .pat_sel   (pat_sel),
      .frame_cnt (frame_cnt),
      .busy      (busy),
      .wdog_err  (wdog_err),
      .state     (state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] pack(input logic g, input logic b, input logic r,
                                         input logic e, input logic [2:0] p,
                                         input logic [15:0] f);
      return {g, b, r, e, p, f};
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string nm, input logic g, input logic b, input logic r,
                             input logic e, input logic [2:0] p, input logic [15:0] f);
      exp_q.push_back(pack(g, b, r, e, p, f));
      name_q.push_back(nm);
   endtask

   task automatic set_cfg(input logic [1:0] m, input logic [2:0] p, input logic [7:0] d);
      cfg_mode  = m;
      cfg_pat   = p;
      cfg_dwell = d;
   endtask

   task automatic send_cfg(input logic [1:0] m, input logic [2:0] p, input logic [7:0] d);
      set_cfg(m, p, d);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic do_frame();
      fv_in = 1'b1;
      repeat (4) tick();
      fv_in = 1'b0;
      tick();
      tick();
   endtask

   // scoreboard monitor
   logic [W-1:0] mon_exp;
   logic [W-1:0] mon_act;
   string        mon_name;

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         mon_act  = pack(gen_en, busy, cfg_ready, wdog_err, pat_sel, frame_cnt);
         compared++;
         if (mon_act !== mon_exp) begin
            mismatched++;
            $display("FAIL %s: got gen_en=%0b busy=%0b cfg_ready=%0b wdog_err=%0b pat_sel=%0d frame_cnt=%0d, want gen_en=%0b busy=%0b cfg_ready=%0b wdog_err=%0b pat_sel=%0d frame_cnt=%0d",
                     mon_name, mon_act[22], mon_act[21], mon_act[20], mon_act[19],
                     mon_act[18:16], mon_act[15:0], mon_exp[22], mon_exp[21],
                     mon_exp[20], mon_exp[19], mon_exp[18:16], mon_exp[15:0]);
         end
      end
   end

   logic wd;

   initial begin
      compared   = 0;
      mismatched = 0;
`ifdef COLORBAR_SEQ_WDOG_EN
      wd = 1'b1;
`else
      wd = 1'b0;
`endif
      rstn      = 1'b0;
      fv_in     = 1'b0;
      cfg_valid = 1'b0;
      step      = 1'b0;
      set_cfg(2'd0, 3'd0, 8'd0);
      repeat (3) tick();
      expect_out("reset_values", 0, 0, 1, 0, 3'd0, 16'd0);
      rstn = 1'b1;
      do_frame();
      expect_out("idle_ignores_bnd", 0, 0, 1, 0, 3'd0, 16'd0);

      // AUTO cycling from pattern 6, dwell 2
      send_cfg(2'd1, 3'd6, 8'd2);
      expect_out("auto_sync", 1, 1, 0, 0, 3'd0, 16'd0);
      do_frame();
      expect_out("auto_bnd1", 1, 1, 1, 0, 3'd6, 16'd0);
      do_frame();
      expect_out("auto_bnd2", 1, 1, 1, 0, 3'd6, 16'd1);
      do_frame();
      expect_out("auto_bnd3", 1, 1, 1, 0, 3'd7, 16'd2);
      do_frame();
      do_frame();
      expect_out("auto_bnd5_wrap", 1, 1, 1, 0, 3'd0, 16'd4);

      // accept on the boundary cycle: must wait for the next boundary
      fv_in = 1'b1;
      repeat (4) tick();
      fv_in = 1'b0;
      set_cfg(2'd0, 3'd5, 8'd1);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      expect_out("accept_on_bnd", 1, 1, 0, 0, 3'd0, 16'd5);
      tick();
      set_cfg(2'd2, 3'd2, 8'd0);
      cfg_valid = 1'b1;
      tick();
      expect_out("held_not_ready", 1, 1, 0, 0, 3'd0, 16'd5);
      fv_in = 1'b1;
      repeat (4) tick();
      fv_in = 1'b0;
      tick();
      expect_out("apply_next_bnd", 1, 1, 1, 0, 3'd5, 16'd6);
      tick();
      cfg_valid = 1'b0;
      expect_out("held_accepted", 1, 1, 0, 0, 3'd5, 16'd6);
      do_frame();
      expect_out("step_mode_applied", 1, 1, 1, 0, 3'd2, 16'd7);

      // STEP: three pulses in one frame give a single advance
      fv_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         tick();
      end
      fv_in = 1'b0;
      tick();
      expect_out("step_collapse", 1, 1, 1, 0, 3'd3, 16'd8);
      tick();
      do_frame();
      expect_out("step_none", 1, 1, 1, 0, 3'd3, 16'd9);
      fv_in = 1'b1;
      repeat (4) tick();
      fv_in = 1'b0;
      step = 1'b1;
      tick();
      step = 1'b0;
      expect_out("step_on_bnd", 1, 1, 1, 0, 3'd3, 16'd10);
      tick();
      do_frame();
      expect_out("step_latched", 1, 1, 1, 0, 3'd4, 16'd11);

      // STOP from RUN
      send_cfg(2'd3, 3'd7, 8'd0);
      expect_out("stop_pending", 1, 1, 0, 0, 3'd4, 16'd11);
      do_frame();
      expect_out("stop_applied", 0, 0, 1, 0, 3'd4, 16'd12);
      do_frame();
      expect_out("stop_stays_idle", 0, 0, 1, 0, 3'd4, 16'd12);

      // restart with AUTO dwell 0 (behaves as 1)
      send_cfg(2'd1, 3'd1, 8'd0);
      expect_out("restart_sync", 1, 1, 0, 0, 3'd4, 16'd12);
      do_frame();
      expect_out("restart_apply", 1, 1, 1, 0, 3'd1, 16'd12);
      do_frame();
      expect_out("dwell0_advance", 1, 1, 1, 0, 3'd2, 16'd13);

      // fv_in stuck high
      fv_in = 1'b1;
      repeat (150) tick();
      if (wd) expect_out("wdog_stuck", 0, 0, 1, 1, 3'd2, 16'd13);
      else    expect_out("wdog_stuck", 1, 1, 1, 0, 3'd2, 16'd13);
      fv_in = 1'b0;
      tick();
      tick();
      if (wd) expect_out("wdog_after", 0, 0, 1, 1, 3'd2, 16'd13);
      else    expect_out("wdog_after", 1, 1, 1, 0, 3'd3, 16'd14);

      // asynchronous reset in the middle of a frame
      fv_in = 1'b1;
      tick();
      tick();
      #2;
      rstn = 1'b0;
      expect_out("reset_async", 0, 0, 1, 0, 3'd0, 16'd0);
      repeat (5) tick();
      expect_out("reset_held", 0, 0, 1, 0, 3'd0, 16'd0);
      rstn = 1'b1;
      tick();
      fv_in = 1'b0;
      tick();
      tick();
      expect_out("reset_first_bnd", 0, 0, 1, 0, 3'd0, 16'd0);
      send_cfg(2'd0, 3'd3, 8'd0);
      expect_out("post_reset_sync", 1, 1, 0, 0, 3'd0, 16'd0);
      do_frame();
      expect_out("post_reset_apply", 1, 1, 1, 0, 3'd3, 16'd0);
      do_frame();
      expect_out("post_reset_hold", 1, 1, 1, 0, 3'd3, 16'd1);

      repeat (3) tick();
      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
